vec_result_drain: RTL
=====================

// Module: vec_result_drain
// PURPOSE
// - Consumer end of the 16-lane vector ALU result/flag interface.
// - Accepts one 256-bit result vector plus 64 bits of per-lane flags in a single handshake.
// - Drains the enabled lanes one 16-bit word per cycle to the narrow data-memory write port,
//   using a valid/ready handshake.
// - Sits between the vector execute stage and data memory. It also reports the lane flags
//   aggregated across all enabled lanes.
// PARAMETERS
// LANES    16  number of vector lanes
// LANE_W   16  bits per lane (result word width)
// FLAG_W   4   flag bits per lane
// ADDR_W   16  memory word-address width
// PORTS
// clk          in   1              single clock; all logic on rising edge
// rst          in   1              synchronous reset, active-high
// in_valid     in   1              result vector offered
// in_ready     out  1              block can capture a vector
// in_result    in   LANES*LANE_W   lane i = in_result[LANE_W*i +: LANE_W]
// in_flags     in   LANES*FLAG_W   lane i = in_flags[FLAG_W*i +: FLAG_W]
// in_lane_mask in   LANES          1 = lane written to memory
// in_base_addr in   ADDR_W         word address of lane 0
// out_valid    out  1              write word offered
// out_ready    in   1              memory accepts word
// out_data     out  LANE_W         lane word
// out_addr     out  ADDR_W         in_base_addr + lane index (mod 2^ADDR_W)
// out_lane     out  log2(LANES)    lane index being written
// out_last     out  1              current word is the last enabled lane
// flags_or     out  FLAG_W         OR of flags over enabled lanes
// flags_and    out  FLAG_W         AND of flags over enabled lanes
// flags_valid  out  1              one-cycle pulse: vector fully drained
// busy         out  1              state != IDLE
// BEHAVIOUR
// - Reset (sync, wins over every other event): state=IDLE.
//   - All outputs 0 except in_ready=1.
//   - Capture registers, flags_or and flags_and cleared.
// - FSM states: IDLE, SEND, DONE.
// - IDLE
//   - in_ready=1.
//   - On in_valid: capture result, flags, mask and base address.
//     - flags_or and flags_and are computed from the captured data and registered.
//     - mask!=0 -> SEND. mask==0 -> DONE.
//   - Empty mask: flags_or=0, flags_and=0.
// - SEND
//   - in_ready=0. out_valid=1.
//   - out_lane = lowest set bit of the remaining mask.
//   - out_data and out_addr are driven from the capture registers.
//     They are held stable while out_valid && !out_ready.
//   - out_last=1 iff exactly one mask bit remains.
//   - On out_ready: clear that mask bit. If it was the last bit -> DONE, else stay in SEND.
// - DONE
//   - flags_valid=1 for exactly one cycle; flags_or and flags_and are valid.
//   - Next state is IDLE.
//   - flags_or and flags_and hold until the next capture.
// - Timing:
//   - Latency from capture edge to first out_valid is 1 cycle.
//   - Throughput is popcount(mask)+2 cycles per vector when out_ready is held high.
// - There is no overlap: a new vector is accepted only in IDLE.
//   in_valid in SEND or DONE is ignored and must be held by the producer.
// - out_addr wraps modulo 2^ADDR_W with no error indication.
// - Lanes are emitted in ascending order. Masked-off lanes produce no cycle and no stall.
// TESTING
// - Full mask 16'hFFFF, lane i data = 16'h1000+i, base 16'h0100, out_ready=1:
//   -> 16 consecutive words.
//   -> Addresses 0x0100..0x010F; out_last only on lane 15.
//   -> flags_valid on cycle 18 after capture.
// - Mask 16'h8421 (lanes 0,5,10,15): -> exactly 4 words with lanes 0,5,10,15.
//   Flags: lane0=4'b0001, lane5=4'b0011, lane10=4'b0001, lane15=4'b1001
//   -> flags_or=4'b1011, flags_and=4'b0001.
// - Mask 16'h0000: -> no out_valid; flags_valid two cycles after capture;
//   flags_or=0, flags_and=0.
// - out_ready toggled randomly with mask 16'hFFFF:
//   -> out_data/out_addr stable while stalled.
//   -> No lane skipped or duplicated; in_ready=0 until IDLE.
// - Base 16'hFFFE with lanes 0..3 enabled -> out_addr FFFE, FFFF, 0000, 0001.
// - rst asserted on the 3rd word of a 16-lane drain:
//   -> next cycle out_valid=0, in_ready=1, flags cleared, no flags_valid pulse.

Source files
------------

// File: rtl/vec_result_drain.sv
// Drains a captured 16-lane result vector to a narrow memory write port, one enabled lane per
// cycle in ascending lane order, and reports the lane flags aggregated over the enabled lanes.
module vec_result_drain #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16,
  parameter int FLAG_W = 4,
  parameter int ADDR_W = 16,
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*LANE_W-1:0]   in_result,
  input  logic [LANES*FLAG_W-1:0]   in_flags,
  input  logic [LANES-1:0]          in_lane_mask,
  input  logic [ADDR_W-1:0]         in_base_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANE_W-1:0]         out_data,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [IDX_W-1:0]          out_lane,
  output logic                      out_last,
  output logic [FLAG_W-1:0]         flags_or,
  output logic [FLAG_W-1:0]         flags_and,
  output logic                      flags_valid,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                    state;
  logic [LANES*LANE_W-1:0]   result_p0;
  logic [LANES-1:0]          mask_p0;
  logic [ADDR_W-1:0]         base_p0;

  logic [IDX_W-1:0]          lane_sel;
  logic                      one_left;
  logic                      send;

  function automatic logic [IDX_W-1:0] lowest_lane(input logic [LANES-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [FLAG_W-1:0] flags_reduce_or(input logic [LANES*FLAG_W-1:0] f,
                                                        input logic [LANES-1:0] m);
    logic [FLAG_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) acc = acc | f[FLAG_W*i +: FLAG_W];
    end
    return acc;
  endfunction

  // An empty mask reports zero rather than the all-ones AND identity.
  function automatic logic [FLAG_W-1:0] flags_reduce_and(input logic [LANES*FLAG_W-1:0] f,
                                                         input logic [LANES-1:0] m);
    logic [FLAG_W-1:0] acc;
    acc = '1;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) acc = acc & f[FLAG_W*i +: FLAG_W];
    end
    return (|m) ? acc : '0;
  endfunction

  assign send      = (state == SEND);
  assign lane_sel  = lowest_lane(mask_p0);
  assign one_left  = (mask_p0 != '0) && ((mask_p0 & (mask_p0 - LANES'(1))) == '0);

  assign in_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign out_valid   = send;
  assign flags_valid = (state == DONE);
  assign out_lane    = send ? lane_sel : '0;
  assign out_last    = send & one_left;
  assign out_data    = send ? result_p0[LANE_W*lane_sel +: LANE_W] : '0;
  assign out_addr    = send ? base_p0 + ADDR_W'(lane_sel) : '0;

  // Stage p0: capture registers plus the drain FSM walking the remaining mask
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      result_p0 <= '0;
      mask_p0   <= '0;
      base_p0   <= '0;
      flags_or  <= '0;
      flags_and <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            result_p0 <= in_result;
            mask_p0   <= in_lane_mask;
            base_p0   <= in_base_addr;
            flags_or  <= flags_reduce_or(in_flags, in_lane_mask);
            flags_and <= flags_reduce_and(in_flags, in_lane_mask);
            state     <= (in_lane_mask != '0) ? SEND : DONE;
          end
        end
        SEND: begin
          if (out_ready) begin
            // Clearing the lowest set bit retires the lane currently on the port.
            mask_p0 <= mask_p0 & (mask_p0 - LANES'(1));
            if (one_left) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
